ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute pipeline stage between the ID stage and the EX/MEM register of the core.
- Accepts a decoded instruction over a valid/ready handshake.
- Forwards operands from the EX/MEM and WB stages, selects ALU operands, drives the combinational ALU and registers its result.
- Resolves branches (BEQ/BNE/BLT) and signals the taken target upstream.

Parameters:
- BITSIZE, 32, datapath width.
- REGADDR, 5, register-address width.

Ports:
- clk  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  ID presents an instruction
- ready_o  out  1  stage can accept
- op_i  in  4  ALU operation code (shared ALU op encoding)
- rs1_addr_i, rs2_addr_i  in  REGADDR  source registers
- rs1_data_i, rs2_data_i  in  BITSIZE  register-file read data
- imm_i  in  BITSIZE  sign-extended immediate
- pc_i  in  BITSIZE  instruction PC
- use_imm_i  in  1  operand B = imm_i
- use_pc_i  in  1  operand A = pc_i
- br_type_i  in  2  0 none, 1 BEQ, 2 BNE, 3 BLT
- rd_addr_i  in  REGADDR  destination register
- rd_we_i  in  1  destination write enable
- wb_we_i  in  1  WB stage writes
- wb_rd_addr_i  in  REGADDR  WB destination register
- wb_data_i  in  BITSIZE  WB data
- alu_a_o, alu_b_o  out  BITSIZE  ALU operands
- alu_op_o  out  4  ALU operation
- alu_result_i  in  BITSIZE  ALU result
- valid_o  out  1  EX/MEM register holds an instruction
- ready_i  in  1  MEM stage accepts
- result_o  out  BITSIZE  registered ALU result
- store_data_o  out  BITSIZE  registered forwarded rs2 value
- rd_addr_o  out  REGADDR  registered destination
- rd_we_o  out  1  registered write enable
- br_taken_o  out  1  one-cycle taken-branch pulse
- br_target_o  out  BITSIZE  registered pc_i + imm_i

Behaviour:
- Reset: valid_o, rd_we_o and br_taken_o are 0. result_o, store_data_o, rd_addr_o and br_target_o are 0.
- ready_o = !valid_o || ready_i. Accept occurs when valid_i && ready_o. Latency is 1 cycle from accept to valid_o.
- Downstream stall (valid_o && !ready_i): all output registers hold, ready_o = 0.
- If ready_i && no accept: valid_o <= 0 and rd_we_o <= 0.
- Forwarding for rs1 and rs2, evaluated independently, priority high to low:
  - EX/MEM: valid_o && rd_we_o && rd_addr_o == rs && rs != 0 -> result_o.
  - WB: wb_we_i && wb_rd_addr_i == rs && rs != 0 -> wb_data_i.
  - Otherwise rs_data_i.
  - Register 0 is never forwarded.
- Load-use hazards are resolved by ID stalling; this stage forwards only registered results.
- Operand selection: alu_a_o = use_pc_i ? pc_i : fwd_rs1. alu_b_o = use_imm_i ? imm_i : fwd_rs2.
- alu_op_o override for branches: br_type 1/2 forces SUBTRACTION; br_type 3 forces LT. Otherwise alu_op_o = op_i.
- Branch decision, combinational at accept:
  - BEQ: alu_result_i == 0.
  - BNE: alu_result_i != 0.
  - BLT: alu_result_i[0] (unsigned compare).
  - Branches capture rd_we_o = 0.
- On an accepted taken branch:
  - br_taken_o <= 1 and br_target_o <= pc_i + imm_i, computed with its own adder, wrap-around modulo 2^BITSIZE.
  - br_taken_o is cleared the next cycle unconditionally.
- Kill cycle (br_taken_o == 1):
  - ready_o is forced to 1; any valid_i instruction is consumed and discarded (wrong path).
  - Registers update as in the no-accept case: the branch entry leaves if ready_i, otherwise it holds.
- store_data_o captures fwd_rs2 (not the immediate).
- Reset asserted mid-stall or during br_taken_o: all state returns to reset values next edge; no pulse survives.

Decomposition:
- Shared package (extends the existing ALU op constants): BR_NONE/BR_EQ/BR_NE/BR_LT encodings, and REGADDR.
- One sub-module, fwd_unit (pure combinational): rs address, EX/MEM and WB tags/data -> forwarded value. Instantiated twice.
- The existing ALU stays outside this block, connected at the core level.

Test Plan:
- Reset: hold rst_i 2 cycles with valid_i = 1 -> valid_o = 0, br_taken_o = 0, rd_we_o = 0.
- ADD: rs1 = 5, rs2 = 7, op = ADDITION, rd = 3 -> next cycle valid_o = 1, result_o = 12, rd_addr_o = 3, rd_we_o = 1.
- Forwarding:
  - Back-to-back ADD x3 = 12, then x4 = x3 + x3 with stale rs1_data_i = 0 -> result_o = 24.
  - WB x5 = 9 concurrently with EX/MEM x5 = 1 -> EX/MEM wins.
  - rs = 0 never forwarded.
- Stall: ready_i = 0 for 3 cycles with valid_o = 1 -> ready_o = 0; result_o, valid_o and rd_* stable; new valid_i not accepted until ready_i = 1.
- Taken branch: BEQ pc = 0x100, imm = 0x20, rs1 = rs2 = 4 -> br_taken_o for exactly one cycle, br_target_o = 0x120; instruction in the following cycle is discarded; rd_we_o = 0.
- Not-taken branch and BLT:
  - BNE with equal operands -> no pulse.
  - BLT 3 < 0xFFFFFFFF -> taken.
  - pc = 0xFFFFFFF0, imm = 0x20 -> target 0x10 (wrap).

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU op codes, branch types and the
// register-address width used across the core.
package ex_stage_pkg;

   localparam int REGADDR = 5;

   typedef enum logic [3:0] {
      ADDITION    = 4'd0,
      SUBTRACTION = 4'd1,
      BITAND      = 4'd2,
      BITOR       = 4'd3,
      BITXOR      = 4'd4,
      LT          = 4'd5,
      SHL         = 4'd6,
      SHR         = 4'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_EQ   = 2'd1,
      BR_NE   = 2'd2,
      BR_LT   = 2'd3
   } br_type_e;

   // EQ/NE look at a SUBTRACTION result, LT at the LSB of an unsigned LT result.
   function automatic logic br_decide(input br_type_e t, input logic res_zero,
                                      input logic res_lsb);
      case (t)
         BR_EQ:   return res_zero;
         BR_NE:   return !res_zero;
         BR_LT:   return res_lsb;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ex_stage_fwd_unit.sv
// Operand forwarding mux: picks the youngest in-flight write to rs, else the
// register-file value. Register 0 is never forwarded.
module fwd_unit
   import ex_stage_pkg::*;
#(
   parameter int BITSIZE  = 32,
   parameter int ADDR_W   = REGADDR
) (
   input  logic [ADDR_W-1:0]  rs_addr_i,
   input  logic [BITSIZE-1:0] rs_data_i,
   input  logic               exm_we_i,
   input  logic [ADDR_W-1:0]  exm_rd_addr_i,
   input  logic [BITSIZE-1:0] exm_data_i,
   input  logic               wb_we_i,
   input  logic [ADDR_W-1:0]  wb_rd_addr_i,
   input  logic [BITSIZE-1:0] wb_data_i,
   output logic [BITSIZE-1:0] fwd_data_o
);

   logic rs_nonzero;
   logic exm_hit;
   logic wb_hit;

   assign rs_nonzero = (rs_addr_i != '0);
   assign exm_hit    = exm_we_i && (exm_rd_addr_i == rs_addr_i) && rs_nonzero;
   assign wb_hit     = wb_we_i  && (wb_rd_addr_i  == rs_addr_i) && rs_nonzero;

   assign fwd_data_o = exm_hit ? exm_data_i :
                       wb_hit  ? wb_data_i  : rs_data_i;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwards operands, drives the external ALU, resolves branches
// and holds the EX/MEM pipeline register behind a valid/ready handshake.
module ex_stage #(
   parameter int BITSIZE = 32,
   parameter int REGADDR = ex_stage_pkg::REGADDR
) (
   input  logic               clk,
   input  logic               rst_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [3:0]         op_i,
   input  logic [REGADDR-1:0] rs1_addr_i,
   input  logic [REGADDR-1:0] rs2_addr_i,
   input  logic [BITSIZE-1:0] rs1_data_i,
   input  logic [BITSIZE-1:0] rs2_data_i,
   input  logic [BITSIZE-1:0] imm_i,
   input  logic [BITSIZE-1:0] pc_i,
   input  logic               use_imm_i,
   input  logic               use_pc_i,
   input  logic [1:0]         br_type_i,
   input  logic [REGADDR-1:0] rd_addr_i,
   input  logic               rd_we_i,
   input  logic               wb_we_i,
   input  logic [REGADDR-1:0] wb_rd_addr_i,
   input  logic [BITSIZE-1:0] wb_data_i,
   output logic [BITSIZE-1:0] alu_a_o,
   output logic [BITSIZE-1:0] alu_b_o,
   output logic [3:0]         alu_op_o,
   input  logic [BITSIZE-1:0] alu_result_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [BITSIZE-1:0] result_o,
   output logic [BITSIZE-1:0] store_data_o,
   output logic [REGADDR-1:0] rd_addr_o,
   output logic               rd_we_o,
   output logic               br_taken_o,
   output logic [BITSIZE-1:0] br_target_o
);

   import ex_stage_pkg::*;

   logic               valid_q,     valid_d;
   logic [BITSIZE-1:0] result_q,    result_d;
   logic [BITSIZE-1:0] store_q,     store_d;
   logic [REGADDR-1:0] rd_addr_q,   rd_addr_d;
   logic               rd_we_q,     rd_we_d;
   logic               br_taken_q,  br_taken_d;
   logic [BITSIZE-1:0] br_target_q, br_target_d;

   logic [BITSIZE-1:0] fwd_rs1;
   logic [BITSIZE-1:0] fwd_rs2;
   logic [BITSIZE-1:0] br_sum;
   br_type_e           br_type;
   logic               accept;
   logic               taken;

   fwd_unit #(.BITSIZE(BITSIZE), .ADDR_W(REGADDR)) u_fwd_rs1 (
      .rs_addr_i     (rs1_addr_i),
      .rs_data_i     (rs1_data_i),
      .exm_we_i      (valid_q && rd_we_q),
      .exm_rd_addr_i (rd_addr_q),
      .exm_data_i    (result_q),
      .wb_we_i       (wb_we_i),
      .wb_rd_addr_i  (wb_rd_addr_i),
      .wb_data_i     (wb_data_i),
      .fwd_data_o    (fwd_rs1)
   );

   fwd_unit #(.BITSIZE(BITSIZE), .ADDR_W(REGADDR)) u_fwd_rs2 (
      .rs_addr_i     (rs2_addr_i),
      .rs_data_i     (rs2_data_i),
      .exm_we_i      (valid_q && rd_we_q),
      .exm_rd_addr_i (rd_addr_q),
      .exm_data_i    (result_q),
      .wb_we_i       (wb_we_i),
      .wb_rd_addr_i  (wb_rd_addr_i),
      .wb_data_i     (wb_data_i),
      .fwd_data_o    (fwd_rs2)
   );

   assign br_type = br_type_e'(br_type_i);
   assign alu_a_o = use_pc_i  ? pc_i  : fwd_rs1;
   assign alu_b_o = use_imm_i ? imm_i : fwd_rs2;
   assign br_sum  = pc_i + imm_i;

   // During the kill cycle the wrong-path instruction is swallowed, never accepted.
   assign ready_o = !valid_q || ready_i || br_taken_q;
   assign accept  = valid_i && ready_o && !br_taken_q;
   assign taken   = br_decide(br_type, (alu_result_i == '0), alu_result_i[0]);

   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      alu_op_o = op_i;
      case (br_type)
         BR_EQ, BR_NE: alu_op_o = SUBTRACTION;
         BR_LT:        alu_op_o = LT;
         default:      ;
      endcase
   end

   always_comb begin
      valid_d     = valid_q;
      result_d    = result_q;
      store_d     = store_q;
      rd_addr_d   = rd_addr_q;
      rd_we_d     = rd_we_q;
      br_taken_d  = 1'b0;
      br_target_d = br_target_q;
      if (accept) begin
         valid_d   = 1'b1;
         result_d  = alu_result_i;
         store_d   = fwd_rs2;
         rd_addr_d = rd_addr_i;
         rd_we_d   = rd_we_i && (br_type == BR_NONE);
         if (taken) begin
            br_taken_d  = 1'b1;
            br_target_d = br_sum;
         end
      end else if (ready_i) begin
         valid_d = 1'b0;
         rd_we_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values together.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         valid_q     <= 1'b0;
         result_q    <= '0;
         store_q     <= '0;
         rd_addr_q   <= '0;
         rd_we_q     <= 1'b0;
         br_taken_q  <= 1'b0;
         br_target_q <= '0;
      end else begin
         valid_q     <= valid_d;
         result_q    <= result_d;
         store_q     <= store_d;
         rd_addr_q   <= rd_addr_d;
         rd_we_q     <= rd_we_d;
         br_taken_q  <= br_taken_d;
         br_target_q <= br_target_d;
      end
   end

   assign valid_o      = valid_q;
   assign result_o     = result_q;
   assign store_data_o = store_q;
   assign rd_addr_o    = rd_addr_q;
   assign rd_we_o      = rd_we_q;
   assign br_taken_o   = br_taken_q;
   assign br_target_o  = br_target_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with a behavioural ALU and an output scoreboard.
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        valid_i, ready_o;
   logic [3:0]  op_i;
   logic [4:0]  rs1_addr_i, rs2_addr_i;
   logic [31:0] rs1_data_i, rs2_data_i, imm_i, pc_i;
   logic        use_imm_i, use_pc_i;
   logic [1:0]  br_type_i;
   logic [4:0]  rd_addr_i;
   logic        rd_we_i;
   logic        wb_we_i;
   logic [4:0]  wb_rd_addr_i;
   logic [31:0] wb_data_i;
   logic [31:0] alu_a_o, alu_b_o;
   logic [3:0]  alu_op_o;
   logic [31:0] alu_result_i;
   logic        valid_o, ready_i;
   logic [31:0] result_o, store_data_o;
   logic [4:0]  rd_addr_o;
   logic        rd_we_o, br_taken_o;
   logic [31:0] br_target_o;

   typedef struct {
      logic [31:0] result;
      logic [31:0] store;
      logic [4:0]  rd;
      logic        we;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .op_i(op_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
      .pc_i(pc_i), .use_imm_i(use_imm_i), .use_pc_i(use_pc_i),
      .br_type_i(br_type_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
      .wb_we_i(wb_we_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_data_i(wb_data_i),
      .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
      .alu_result_i(alu_result_i), .valid_o(valid_o), .ready_i(ready_i),
      .result_o(result_o), .store_data_o(store_data_o), .rd_addr_o(rd_addr_o),
      .rd_we_o(rd_we_o), .br_taken_o(br_taken_o), .br_target_o(br_target_o)
   );

   // Core-level ALU stand-in.
   always_comb begin
      case (alu_op_o)
         4'd0:    alu_result_i = alu_a_o + alu_b_o;
         4'd1:    alu_result_i = alu_a_o - alu_b_o;
         4'd2:    alu_result_i = alu_a_o & alu_b_o;
         4'd3:    alu_result_i = alu_a_o | alu_b_o;
         4'd4:    alu_result_i = alu_a_o ^ alu_b_o;
         4'd5:    alu_result_i = {31'd0, alu_a_o < alu_b_o};
         4'd6:    alu_result_i = alu_a_o << alu_b_o[4:0];
         4'd7:    alu_result_i = alu_a_o >> alu_b_o[4:0];
         default: alu_result_i = 32'd0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] a2, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic ui, input logic up, input logic [1:0] br,
                        input logic [4:0] rd, input logic we);
      valid_i    = 1'b1;
      op_i       = op;
      rs1_addr_i = a1;  rs1_data_i = d1;
      rs2_addr_i = a2;  rs2_data_i = d2;
      imm_i      = imm; pc_i       = pc;
      use_imm_i  = ui;  use_pc_i   = up;
      br_type_i  = br;
      rd_addr_i  = rd;  rd_we_i    = we;
   endtask

   task automatic push(input logic [31:0] r, input logic [31:0] s, input logic [4:0] rd,
                       input logic we);
      exp_t e;
      e.result = r; e.store = s; e.rd = rd; e.we = we;
      sb.push_back(e);
   endtask

   // Scoreboard: an entry leaves the EX/MEM register whenever valid_o && ready_i.
   always @(negedge clk) begin
      if (!rst_i && valid_o && ready_i) begin
         compared++;
         assert (sb.size() != 0) else begin
            mismatched++;
            $error("FAIL sb_unexpected: observed result 0x%08h rd %0d expected no output",
                   result_o, rd_addr_o);
         end
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("sb_result", result_o, e.result);
            check("sb_store",  store_data_o, e.store);
            check("sb_rd",     {27'd0, rd_addr_o}, {27'd0, e.rd});
            check("sb_we",     {31'd0, rd_we_o}, {31'd0, e.we});
         end
      end
   end

   initial begin
      rst_i   = 1'b1;
      ready_i = 1'b1;
      wb_we_i = 1'b0; wb_rd_addr_i = 5'd0; wb_data_i = 32'd0;
      drive(ADDITION, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, BR_NONE, 5'd3, 1'b1);

      // Reset held with valid_i asserted
      tick(); tick();
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_brtaken", {31'd0, br_taken_o}, 32'd0);
      check("rst_rdwe", {31'd0, rd_we_o}, 32'd0);
      check("rst_result", result_o, 32'd0);
      check("rst_target", br_target_o, 32'd0);
      check("rst_ready", {31'd0, ready_o}, 32'd1);
      rst_i = 1'b0;

      // x3 = 5 + 7
      push(32'd12, 32'd7, 5'd3, 1'b1);
      tick();
      check("add_valid", {31'd0, valid_o}, 32'd1);
      check("add_result", result_o, 32'd12);
      check("add_rd", {27'd0, rd_addr_o}, 32'd3);
      check("add_we", {31'd0, rd_we_o}, 32'd1);

      // x4 = x3 + x3, stale register data, EX/MEM forward
      drive(ADDITION, 5'd3, 32'd0, 5'd3, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, BR_NONE, 5'd4, 1'b1);
      push(32'd24, 32'd12, 5'd4, 1'b1);
      tick();
      check("fwd_exm_result", result_o, 32'd24);

      // x5 = x0 + 1
      drive(ADDITION, 5'd0, 32'd0, 5'd0, 32'd0, 32'd1, 32'd0, 1'b1, 1'b0, BR_NONE, 5'd5, 1'b1);
      push(32'd1, 32'd0, 5'd5, 1'b1);
      tick();

      // x6 = x5 + x5 with WB x5 = 9 competing: EX/MEM wins
      drive(ADDITION, 5'd5, 32'hDEAD, 5'd5, 32'hDEAD, 32'd0, 32'd0, 1'b0, 1'b0, BR_NONE, 5'd6, 1'b1);
      wb_we_i = 1'b1; wb_rd_addr_i = 5'd5; wb_data_i = 32'd9;
      push(32'd2, 32'd1, 5'd6, 1'b1);
      tick();
      check("fwd_prio_result", result_o, 32'd2);
      wb_we_i = 1'b0;

      // x0 = 0x30 + 0x40 (writes to x0 must not be forwarded)
      drive(ADDITION, 5'd1, 32'h30, 5'd2, 32'h40, 32'd0, 32'd0, 1'b0, 1'b0, BR_NONE, 5'd0, 1'b1);
      push(32'h70, 32'h40, 5'd0, 1'b1);
      tick();

      // x7 = x0 + x0 with EX/MEM and WB both targeting x0
      drive(ADDITION, 5'd0, 32'h11, 5'd0, 32'h22, 32'd0, 32'd0, 1'b0, 1'b0, BR_NONE, 5'd7, 1'b1);
      wb_we_i = 1'b1; wb_rd_addr_i = 5'd0; wb_data_i = 32'h99;
      push(32'h33, 32'h22, 5'd7, 1'b1);
      tick();
      check("fwd_x0_result", result_o, 32'h33);

      // x8 = x9 + x1 with WB-only forward of x9
      drive(ADDITION, 5'd9, 32'd0, 5'd1, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, BR_NONE, 5'd8, 1'b1);
      wb_rd_addr_i = 5'd9; wb_data_i = 32'h100;
      push(32'h105, 32'd5, 5'd8, 1'b1);
      tick();
      check("fwd_wb_result", result_o, 32'h105);
      wb_we_i = 1'b0;

      // Downstream stall for 3 cycles with a new instruction waiting
      drive(ADDITION, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, BR_NONE, 5'd10, 1'b1);
      ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_ready", {31'd0, ready_o}, 32'd0);
         check("stall_valid", {31'd0, valid_o}, 32'd1);
         check("stall_result", result_o, 32'h105);
         check("stall_rd", {27'd0, rd_addr_o}, 32'd8);
         check("stall_we", {31'd0, rd_we_o}, 32'd1);
      end
      ready_i = 1'b1;
      push(32'd3, 32'd2, 5'd10, 1'b1);
      tick();
      check("post_stall_result", result_o, 32'd3);
      check("post_stall_rd", {27'd0, rd_addr_o}, 32'd10);

      // Taken BEQ, then wrong-path instruction during the kill cycle with MEM stalled
      drive(ADDITION, 5'd1, 32'd4, 5'd2, 32'd4, 32'h20, 32'h100, 1'b0, 1'b0, BR_EQ, 5'd9, 1'b1);
      push(32'd0, 32'd4, 5'd9, 1'b0);
      tick();
      check("beq_taken", {31'd0, br_taken_o}, 32'd1);
      check("beq_target", br_target_o, 32'h120);
      check("beq_we", {31'd0, rd_we_o}, 32'd0);
      drive(ADDITION, 5'd1, 32'd1, 5'd2, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, BR_NONE, 5'd11, 1'b1);
      ready_i = 1'b0;
      #1;
      check("kill_ready", {31'd0, ready_o}, 32'd1);
      tick();
      check("kill_pulse_off", {31'd0, br_taken_o}, 32'd0);
      check("kill_hold_valid", {31'd0, valid_o}, 32'd1);
      check("kill_hold_rd", {27'd0, rd_addr_o}, 32'd9);
      check("kill_hold_result", result_o, 32'd0);
      valid_i = 1'b0;
      ready_i = 1'b1;
      tick();
      check("kill_discard", {31'd0, valid_o}, 32'd0);

      // BNE with equal operands: not taken
      drive(ADDITION, 5'd1, 32'h55, 5'd2, 32'h55, 32'h40, 32'h200, 1'b0, 1'b0, BR_NE, 5'd12, 1'b1);
      push(32'd0, 32'h55, 5'd12, 1'b0);
      tick();
      check("bne_taken", {31'd0, br_taken_o}, 32'd0);
      check("bne_target_hold", br_target_o, 32'h120);

      // BLT 3 < 0xFFFFFFFF taken, target wraps
      drive(ADDITION, 5'd1, 32'd3, 5'd2, 32'hFFFF_FFFF, 32'h20, 32'hFFFF_FFF0, 1'b0, 1'b0,
            BR_LT, 5'd13, 1'b1);
      push(32'd1, 32'hFFFF_FFFF, 5'd13, 1'b0);
      tick();
      check("blt_taken", {31'd0, br_taken_o}, 32'd1);
      check("blt_wrap_target", br_target_o, 32'h10);
      valid_i = 1'b0;
      tick();
      check("blt_pulse_off", {31'd0, br_taken_o}, 32'd0);

      // BLT 0xFFFFFFFF < 3 not taken
      drive(ADDITION, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd3, 32'd4, 32'h300, 1'b0, 1'b0,
            BR_LT, 5'd14, 1'b1);
      push(32'd0, 32'd3, 5'd14, 1'b0);
      tick();
      check("blt_nt_taken", {31'd0, br_taken_o}, 32'd0);
      check("blt_nt_target", br_target_o, 32'h10);

      // PC-relative add
      drive(ADDITION, 5'd1, 32'd0, 5'd2, 32'h77, 32'h10, 32'h1000, 1'b1, 1'b1, BR_NONE, 5'd16, 1'b1);
      push(32'h1010, 32'h77, 5'd16, 1'b1);
      tick();
      check("pcrel_result", result_o, 32'h1010);

      // Reset asserted while the taken pulse is high
      drive(ADDITION, 5'd1, 32'd1, 5'd2, 32'd1, 32'd8, 32'h400, 1'b0, 1'b0, BR_EQ, 5'd15, 1'b1);
      push(32'd0, 32'd1, 5'd15, 1'b0);
      tick();
      check("pre_rst_taken", {31'd0, br_taken_o}, 32'd1);
      check("pre_rst_target", br_target_o, 32'h408);
      valid_i = 1'b0;
      rst_i   = 1'b1;
      sb.delete();
      tick();
      check("mid_rst_taken", {31'd0, br_taken_o}, 32'd0);
      check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
      check("mid_rst_target", br_target_o, 32'd0);
      check("mid_rst_result", result_o, 32'd0);
      rst_i = 1'b0;
      tick();
      check("post_rst_valid", {31'd0, valid_o}, 32'd0);

      check("sb_drain", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
